// File: rtl/pipe_skid_reg_pkg.sv
// Occupancy encodings shared by the skid-buffered pipeline stage.
// The numeric value of each state is also the held-entry count.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_BUSY  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_skid_reg_dff.sv
// Load-enabled register with asynchronous active-high reset to a fixed value.
// Latency: 1 cycle from load to q. No handshake; the owner decides when to load.
// Backpressure: none. The register holds its value whenever en is low.
module pipe_skid_reg_dff #(
    parameter int            DW      = 32,
    parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake, a two-entry skid buffer, flush and bubble output.
// Latency: 1 cycle. Backpressure: in_ready is registered and drops one cycle after a stall, with the skid catching the in-flight beat.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int            DW         = 32,
    parameter logic [DW-1:0] BUBBLE_VAL = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occ
);

    occ_e          state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          main_en, skid_en;
    logic [DW-1:0] main_d, main_q, skid_q;
    logic          in_acc, out_acc;

    assign in_acc  = in_valid & in_ready_q;
    assign out_acc = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = in_data;
        skid_en = 1'b0;

        unique case (state_q)
            OCC_EMPTY: begin
                if (in_acc) begin
                    main_en = 1'b1;
                    state_d = OCC_BUSY;
                end
            end
            OCC_BUSY: begin
                if (in_acc && out_acc) begin
                    main_en = 1'b1;
                end else if (in_acc) begin
                    skid_en = 1'b1;
                    state_d = OCC_FULL;
                end else if (out_acc) begin
                    main_en = 1'b1;
                    main_d  = BUBBLE_VAL;
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (out_acc) begin
                    main_en = 1'b1;
                    main_d  = skid_q;
                    state_d = OCC_BUSY;
                end
            end
            default: begin
                main_en = 1'b1;
                main_d  = BUBBLE_VAL;
                state_d = OCC_EMPTY;
            end
        endcase

        // Flush beats everything: any beat accepted this cycle is dropped.
        if (flush) begin
            state_d = OCC_EMPTY;
            main_en = 1'b1;
            main_d  = BUBBLE_VAL;
            skid_en = 1'b0;
        end

        in_ready_d = (state_d != OCC_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_skid_reg_dff #(
        .DW      (DW),
        .RST_VAL (BUBBLE_VAL)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_skid_reg_dff #(
        .DW      (DW),
        .RST_VAL (BUBBLE_VAL)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = main_q;
    assign occ       = state_q;

endmodule
